// File: rtl/vdmem_pkg.sv
// Shared constants and helpers for the lane-banked vector data memory.
// Default geometry, address/row width helpers and the lane rotation used on both data paths.
package vdmem_pkg;

   localparam int DEFAULT_LANES  = 16;
   localparam int DEFAULT_LANE_W = 16;
   localparam int DEFAULT_DEPTH  = 1024;

   // Widest vector the rotation helper handles; callers zero-extend into it and truncate back.
   localparam int MAX_VEC_W = 4096;

   function automatic int addr_width(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int row_width(input int depth, input int lanes);
      return $clog2(depth / lanes);
   endfunction

   // Result lane l takes source lane (l + amount) mod lanes.
   function automatic logic [MAX_VEC_W-1:0] rotate_lanes(
      input logic [MAX_VEC_W-1:0] data,
      input int unsigned          amount,
      input int unsigned          lanes,
      input int unsigned          lane_w
   );
      logic [MAX_VEC_W-1:0] result;
      result = '0;
      for (int unsigned b = 0; b < MAX_VEC_W; b++) begin
         if (b < lanes * lane_w)
            result[b] = data[((b / lane_w + amount) % lanes) * lane_w + b % lane_w];
      end
      return result;
   endfunction

endpackage

// File: rtl/vdmem_bank.sv
// One storage bank of the vector data memory: single write port with enable,
// combinational read from the same row address.
module vdmem_bank
   import vdmem_pkg::*;
#(
   parameter int ROWS   = DEFAULT_DEPTH / DEFAULT_LANES,
   parameter int ROW_W  = $clog2(DEFAULT_DEPTH / DEFAULT_LANES),
   parameter int LANE_W = DEFAULT_LANE_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ROW_W-1:0]  addr,
   input  logic [LANE_W-1:0] wdata,
   output logic [LANE_W-1:0] rdata
);

   logic [LANE_W-1:0] mem [ROWS];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/vector_data_memory.sv
// Lane-banked vector memory with unaligned single-access reads/writes and a one-deep response stage.
// Optional feature: define VDMEM_BOUNDS_CHECK_EN to reject accesses running past DEPTH instead of wrapping.
module vector_data_memory
   import vdmem_pkg::*;
#(
   parameter int LANES  = DEFAULT_LANES,
   parameter int LANE_W = DEFAULT_LANE_W,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_we,
   input  logic [$clog2(DEPTH)-1:0]   req_addr,
   input  logic [LANES*LANE_W-1:0]    req_wdata,
   input  logic [LANES-1:0]           req_mask,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [LANES*LANE_W-1:0]    rsp_rdata,
   output logic                       rsp_err
);

   localparam int ADDR_W = addr_width(DEPTH);
   localparam int ROW_W  = row_width(DEPTH, LANES);
   localparam int SEL_W  = $clog2(LANES);
   localparam int ROWS   = DEPTH / LANES;
   localparam int VEC_W  = LANES * LANE_W;
   localparam int unsigned LANES_U  = LANES;
   localparam int unsigned LANE_W_U = LANE_W;

   logic                 accept;
   logic                 oob;
   logic [SEL_W-1:0]     rot;
   logic [ROW_W-1:0]     base_row;
   logic [ROW_W-1:0]     next_row;
   int unsigned          rot_amt;
   int unsigned          wr_amt;
   logic [VEC_W-1:0]     rot_wdata;
   logic [LANES-1:0]     rot_mask;
   logic [LANES-1:0]     bank_we;
   logic [VEC_W-1:0]     bank_rdata;
   logic [VEC_W-1:0]     derot_rdata;

   assign req_ready = !rsp_valid || rsp_ready;
   assign accept    = req_valid && req_ready;

   assign rot      = req_addr[SEL_W-1:0];
   assign base_row = req_addr[ADDR_W-1:SEL_W];
   assign next_row = (base_row == ROW_W'(ROWS - 1)) ? '0 : base_row + ROW_W'(1);

`ifdef VDMEM_BOUNDS_CHECK_EN
   logic [ADDR_W:0] addr_end;
   assign addr_end = {1'b0, req_addr} + (ADDR_W+1)'(LANES);
   assign oob      = addr_end > (ADDR_W+1)'(DEPTH);
`else
   assign oob = 1'b0;
`endif

   // Request lane i lands in bank (rot + i) mod LANES, so writes rotate up and reads rotate back down.
   assign rot_amt = 32'(rot);
   assign wr_amt  = (LANES_U - rot_amt) % LANES_U;

   assign rot_wdata   = VEC_W'(rotate_lanes(MAX_VEC_W'(req_wdata), wr_amt, LANES_U, LANE_W_U));
   assign rot_mask    = LANES'(rotate_lanes(MAX_VEC_W'(req_mask), wr_amt, LANES_U, 1));
   assign derot_rdata = VEC_W'(rotate_lanes(MAX_VEC_W'(bank_rdata), rot_amt, LANES_U, LANE_W_U));

   assign bank_we = {LANES{accept && req_we && !oob}} & rot_mask;

   // Banks below the rotation point hold the tail of the vector, one row further on.
   for (genvar b = 0; b < LANES; b++) begin : g_bank
      localparam int unsigned BANK = b;
      logic [ROW_W-1:0] row;

      assign row = (BANK >= rot_amt) ? base_row : next_row;

      vdmem_bank #(
         .ROWS   (ROWS),
         .ROW_W  (ROW_W),
         .LANE_W (LANE_W)
      ) u_bank (
         .clk   (clk),
         .we    (bank_we[b]),
         .addr  (row),
         .wdata (rot_wdata[b*LANE_W +: LANE_W]),
         .rdata (bank_rdata[b*LANE_W +: LANE_W])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= (req_we || oob) ? '0 : derot_rdata;
         rsp_err   <= oob;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vector_data_memory.sv
// Scoreboard bench for vector_data_memory: a flat element model predicts every response,
// which is queued at request acceptance and compared when the DUT hands the response over.
module tb_vector_data_memory;

   localparam int LANES = 16;
   localparam int LANE_W = 16;
   localparam int DEPTH = 1024;
   localparam int VEC_W = LANES * LANE_W;
`ifdef VDMEM_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   typedef struct {
      logic [VEC_W-1:0] data;
      logic             err;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [9:0]       req_addr;
   logic [VEC_W-1:0] req_wdata;
   logic [LANES-1:0] req_mask;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [VEC_W-1:0] rsp_rdata;
   logic             rsp_err;

   exp_t             sb[$];
   logic [15:0]      model_mem [DEPTH];
   int               checks;
   int               errors;

   vector_data_memory #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_mask  (req_mask),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [VEC_W-1:0] actual, input logic [VEC_W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Drive one request starting at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic applyStimulus(input logic we, input logic [9:0] addr, input logic [VEC_W-1:0] wdata,
                                input logic [LANES-1:0] mask, output int waits);
      exp_t e;
      bit   oob;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_mask  = mask;
      waits     = 0;
      #1;
      while (!req_ready && waits < 50) begin
         @(posedge clk);
         #2;
         waits++;
      end
      if (!req_ready) begin
         checkOutput("req_accept_timeout", VEC_W'(req_ready), VEC_W'(1));
         @(posedge clk);
         #1;
         req_valid = 1'b0;
      end else begin
         oob    = BOUNDS_EN && (int'(addr) + LANES > DEPTH);
         e.err  = oob;
         e.data = '0;
         if (!oob) begin
            for (int i = 0; i < LANES; i++) begin
               if (we) begin
                  if (mask[i]) model_mem[(int'(addr) + i) % DEPTH] = wdata[i*LANE_W +: LANE_W];
               end else begin
                  e.data[i*LANE_W +: LANE_W] = model_mem[(int'(addr) + i) % DEPTH];
               end
            end
         end
         sb.push_back(e);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
      end
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
   endtask

   // A response is handed over at the next edge whenever valid and ready are both high here.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checkOutput("sb_unexpected_rsp", VEC_W'(1), VEC_W'(0));
            end else begin
               e = sb.pop_front();
               checkOutput("rsp_rdata", rsp_rdata, e.data);
               checkOutput("rsp_err", VEC_W'(rsp_err), VEC_W'(e.err));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int               w;
      int               n;
      logic [VEC_W-1:0] vec;
      logic [VEC_W-1:0] held;

      checks = 0;
      errors = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_mask  = '0;
      rsp_ready = 1'b1;

      #12;
      checkOutput("reset_rsp_valid", VEC_W'(rsp_valid), VEC_W'(0));
      checkOutput("reset_rsp_rdata", rsp_rdata, VEC_W'(0));
      checkOutput("reset_rsp_err", VEC_W'(rsp_err), VEC_W'(0));
      checkOutput("reset_req_ready", VEC_W'(req_ready), VEC_W'(1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      idleCycle();

      $display("[TB] clearing memory");
      for (int k = 0; k < DEPTH / LANES; k++) applyStimulus(1'b1, 10'(k * LANES), '0, 16'hFFFF, w);

      $display("[TB] aligned write/read");
      for (int i = 0; i < LANES; i++) vec[i*LANE_W +: LANE_W] = 16'(16'h0100 + i);
      applyStimulus(1'b1, 10'd0, vec, 16'hFFFF, w);
      applyStimulus(1'b0, 10'd0, '0, 16'h0000, w);
      checkOutput("read_latency_valid", VEC_W'(rsp_valid), VEC_W'(1));

      $display("[TB] unaligned read and masked unaligned write");
      applyStimulus(1'b0, 10'd5, '0, 16'h0000, w);
      vec = {LANES{16'hAAAA}};
      applyStimulus(1'b1, 10'd5, vec, 16'h00FF, w);
      applyStimulus(1'b0, 10'd0, '0, 16'h0000, w);

      $display("[TB] back-pressure");
      idleCycle();
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 10'd0, '0, 16'h0000, w);
      checkOutput("bp_rsp_valid", VEC_W'(rsp_valid), VEC_W'(1));
      held = rsp_rdata;
      fork
         begin
            repeat (3) begin
               @(posedge clk);
               #1;
               checkOutput("bp_req_ready", VEC_W'(req_ready), VEC_W'(0));
               checkOutput("bp_rdata_stable", rsp_rdata, held);
            end
            rsp_ready = 1'b1;
         end
         applyStimulus(1'b0, 10'd5, '0, 16'h0000, w);
      join
      checkOutput("bp_wait_cycles", VEC_W'(w), VEC_W'(3));

      $display("[TB] wrap-around / bounds");
      for (int i = 0; i < LANES; i++) vec[i*LANE_W +: LANE_W] = 16'(16'h0200 + i);
      applyStimulus(1'b1, 10'd1020, vec, 16'hFFFF, w);
      applyStimulus(1'b0, 10'd1020, '0, 16'h0000, w);
      applyStimulus(1'b0, 10'd0, '0, 16'h0000, w);
      applyStimulus(1'b0, 10'd1008, '0, 16'h0000, w);

      $display("[TB] random traffic");
      for (int t = 0; t < 24; t++) begin
         for (int j = 0; j < VEC_W / 32; j++) vec[j*32 +: 32] = $urandom;
         applyStimulus(1'($urandom_range(0, 1)), 10'($urandom_range(0, DEPTH - 1)), vec,
                       16'($urandom_range(0, 65535)), w);
      end

      $display("[TB] reset with a held response");
      idleCycle();
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 10'd0, '0, 16'h0000, w);
      rst = 1'b0;
      #1;
      checkOutput("midrst_rsp_valid", VEC_W'(rsp_valid), VEC_W'(0));
      checkOutput("midrst_rsp_rdata", rsp_rdata, VEC_W'(0));
      checkOutput("midrst_rsp_err", VEC_W'(rsp_err), VEC_W'(0));
      checkOutput("midrst_sb_pending", VEC_W'(sb.size()), VEC_W'(1));
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      rsp_ready = 1'b1;
      applyStimulus(1'b0, 10'd0, '0, 16'h0000, w);
      applyStimulus(1'b0, 10'd1020, '0, 16'h0000, w);
      applyStimulus(1'b0, 10'd517, '0, 16'h0000, w);

      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      checkOutput("sb_drain", VEC_W'(sb.size()), VEC_W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
